display_hex_byte_decoder: RTL and testbench

Passive decoder for the three-digit multiplexed seven-segment bus: samples the active-low segment and digit-enable lines produced by the board's hex-byte display driver and recovers the byte being shown. Sits alongside the driver on the same pins, or in a loopback bench, and gives self-test logic and the verification bench a registered copy of the displayed value, a per-frame valid pulse and a lock indication.

---
 rtl/display_hex_byte_decoder_if.sv | 20 ++
 rtl/display_hex_byte_decoder.sv | 155 +++++++++++++++
 tb/tb_display_hex_byte_decoder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/display_hex_byte_decoder_if.sv
// Multiplexed seven-segment bus plus the decoded-byte outputs of the passive decoder.
// The master side drives the pins; the slave side is the decoder.
interface display_hex_byte_decoder_if;
  logic [7:0] segments;
  logic [2:0] segments_enable;
  logic [7:0] hex_byte;
  logic       byte_valid;
  logic       frame_error;
  logic       locked;

  modport master (
    output segments, segments_enable,
    input  hex_byte, byte_valid, frame_error, locked
  );

  modport slave (
    input  segments, segments_enable,
    output hex_byte, byte_valid, frame_error, locked
  );
endinterface

// File: rtl/display_hex_byte_decoder.sv
// Passive decoder for the 3-digit multiplexed active-low seven-segment bus.
// Recovers the displayed byte from marker/high/low digit sequences.
module display_hex_byte_decoder #(
  parameter int unsigned settle_cycles  = 16,
  parameter int unsigned timeout_cycles = 250000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  display_hex_byte_decoder_if.slave    bus
);

  typedef enum logic [1:0] {S_MARK, S_HIGH, S_LOW} state_t;

  localparam logic [6:0]  MARKER_GLYPH = 7'b0010111;
  localparam logic [15:0] SETTLE_MAX   = 16'(settle_cycles);
  localparam logic [15:0] SETTLE_LAST  = 16'(settle_cycles - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(timeout_cycles - 1);

  logic [10:0] s1_q, s2_q, s3_q;
  logic [15:0] settle_q, settle_d;
  state_t      state_q, state_d;
  logic [3:0]  hi_q, hi_d;
  logic [7:0]  hex_byte_q, hex_byte_d;
  logic        byte_valid_q, byte_valid_d;
  logic        frame_error_q, frame_error_d;
  logic        locked_q, locked_d;
  logic [23:0] to_q, to_d;

  logic       change, dig_evt;
  logic [6:0] glyph;
  logic [2:0] en;
  logic       glyph_ok;
  logic [3:0] glyph_nib;
  logic       is_marker, is_high, is_low, is_blank;

  // {valid, nibble} for a segment pattern a..g
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    case (g)
      7'b1111110: return 5'h10;
      7'b0110000: return 5'h11;
      7'b1101101: return 5'h12;
      7'b1111001: return 5'h13;
      7'b0110011: return 5'h14;
      7'b1011011: return 5'h15;
      7'b1011111: return 5'h16;
      7'b1110000: return 5'h17;
      7'b1111111: return 5'h18;
      7'b1111011: return 5'h19;
      7'b1110111: return 5'h1A;
      7'b0011111: return 5'h1B;
      7'b1001110: return 5'h1C;
      7'b0111101: return 5'h1D;
      7'b1001111: return 5'h1E;
      7'b1000111: return 5'h1F;
      default:    return 5'h00;
    endcase
  endfunction

  always_comb begin
    change = (s2_q != s3_q);
    // s2 == s3 whenever an event fires, so s2 carries the stable digit
    glyph  = ~s2_q[10:4];
    en     = ~s2_q[2:0];
    {glyph_ok, glyph_nib} = decode_glyph(glyph);
    is_blank  = (en == 3'b000);
    is_marker = (en == 3'b100) && (glyph == MARKER_GLYPH);
    is_high   = (en == 3'b010) && glyph_ok;
    is_low    = (en == 3'b001) && glyph_ok;

    if (change)                  settle_d = '0;
    else if (settle_q < SETTLE_MAX) settle_d = settle_q + 16'd1;
    else                         settle_d = settle_q;
    dig_evt = !change && (settle_q == SETTLE_LAST);

    state_d       = state_q;
    hi_d          = hi_q;
    hex_byte_d    = hex_byte_q;
    byte_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    locked_d      = locked_q;
    to_d          = locked_q ? to_q + 24'd1 : '0;

    if (dig_evt && !is_blank) begin
      case (state_q)
        S_MARK: if (is_marker) state_d = S_HIGH;
        S_HIGH: begin
          if (is_high) begin
            hi_d    = glyph_nib;
            state_d = S_LOW;
          end else if (!is_marker) begin
            frame_error_d = 1'b1;
            state_d       = S_MARK;
          end
        end
        S_LOW: begin
          if (is_low) begin
            hex_byte_d   = {hi_q, glyph_nib};
            byte_valid_d = 1'b1;
            locked_d     = 1'b1;
            state_d      = S_MARK;
          end else begin
            frame_error_d = 1'b1;
            state_d       = is_marker ? S_HIGH : S_MARK;
          end
        end
        default: state_d = S_MARK;
      endcase
    end

    if (frame_error_d) locked_d = 1'b0;

    // A completed byte beats a coincident timeout
    if (byte_valid_d) begin
      to_d = '0;
    end else if (locked_q && (to_q == TIMEOUT_LAST)) begin
      locked_d = 1'b0;
      state_d  = S_MARK;
      to_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q          <= '1;
      s2_q          <= '1;
      s3_q          <= '1;
      settle_q      <= '0;
      state_q       <= S_MARK;
      hi_q          <= '0;
      hex_byte_q    <= '0;
      byte_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      locked_q      <= 1'b0;
      to_q          <= '0;
    end else begin
      s1_q          <= {bus.segments, bus.segments_enable};
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      settle_q      <= settle_d;
      state_q       <= state_d;
      hi_q          <= hi_d;
      hex_byte_q    <= hex_byte_d;
      byte_valid_q  <= byte_valid_d;
      frame_error_q <= frame_error_d;
      locked_q      <= locked_d;
      to_q          <= to_d;
    end
  end

  assign bus.hex_byte    = hex_byte_q;
  assign bus.byte_valid  = byte_valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.locked      = locked_q;

endmodule

// File: tb/tb_display_hex_byte_decoder.sv
// Directed bench for display_hex_byte_decoder: frames, glitch, bad glyph,
// mid-frame start, lock timeout and asynchronous reset.
module tb_display_hex_byte_decoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  display_hex_byte_decoder_if bus_if ();

  display_hex_byte_decoder #(
    .settle_cycles (16),
    .timeout_cycles(1000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  localparam logic [7:0] G_MARK = 8'b00101110;
  localparam logic [7:0] G_0 = 8'b11111100;
  localparam logic [7:0] G_1 = 8'b01100000;
  localparam logic [7:0] G_2 = 8'b11011010;
  localparam logic [7:0] G_3 = 8'b11110010;
  localparam logic [7:0] G_5 = 8'b10110110;
  localparam logic [7:0] G_7 = 8'b11100000;
  localparam logic [7:0] G_A = 8'b11101110;
  localparam logic [7:0] G_C = 8'b10011100;
  localparam logic [7:0] G_E = 8'b10011110;
  localparam logic [7:0] G_BAD = 8'b00000010;

  int n_assert = 0;
  int n_fail   = 0;
  int bv_cnt   = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;
  int bv0, fe0;
  int e, fall;

  always @(negedge clk) begin
    if (bus_if.byte_valid) bv_cnt++;
    if (bus_if.frame_error) fe_cnt++;
    if (bus_if.byte_valid && bus_if.frame_error) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] seg, input logic [2:0] en);
    bus_if.segments        = ~seg;
    bus_if.segments_enable = ~en;
  endtask

  task automatic hold(input logic [7:0] seg, input logic [2:0] en, input int n);
    put(seg, en);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds a low digit 40 cycles and reports the edge (edge 0 = s1 capture) of byte_valid
  task automatic low_measure(input logic [7:0] seg, output int edge_at);
    put(seg, 3'b001);
    edge_at = -1;
    @(posedge clk);
    #1;
    for (int i = 1; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.byte_valid && edge_at < 0) edge_at = i;
    end
  endtask

  task automatic snap();
    bv0 = bv_cnt;
    fe0 = fe_cnt;
  endtask

  initial begin
    rst_n = 1'b0;
    put(8'h00, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hex", bus_if.hex_byte, 8'h00);
    chk("rst_bv", bus_if.byte_valid, 1'b0);
    chk("rst_fe", bus_if.frame_error, 1'b0);
    chk("rst_locked", bus_if.locked, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good frame A5 with latency measurement
    snap();
    hold(G_MARK, 3'b100, 40);
    hold(G_A, 3'b010, 40);
    chk("t1_prelock", bus_if.locked, 1'b0);
    chk("t1_prehex", bus_if.hex_byte, 8'h00);
    low_measure(G_5, e);
    chk("t1_latency", e, 18);
    chk("t1_hex", bus_if.hex_byte, 8'hA5);
    chk("t1_locked", bus_if.locked, 1'b1);
    chk("t1_bv_count", bv_cnt - bv0, 1);
    chk("t1_fe_count", fe_cnt - fe0, 0);

    // Short enable glitch inside the high digit
    snap();
    hold(G_MARK, 3'b100, 40);
    hold(G_A, 3'b010, 10);
    hold(G_A, 3'b001, 8);
    hold(G_A, 3'b010, 40);
    hold(G_5, 3'b001, 40);
    chk("t2_bv_count", bv_cnt - bv0, 1);
    chk("t2_fe_count", fe_cnt - fe0, 0);
    chk("t2_hex", bus_if.hex_byte, 8'hA5);
    chk("t2_locked", bus_if.locked, 1'b1);

    // Malformed high digit, then relock on 3C
    snap();
    hold(G_MARK, 3'b100, 40);
    hold(G_BAD, 3'b010, 40);
    chk("t3_fe_count", fe_cnt - fe0, 1);
    chk("t3_unlocked", bus_if.locked, 1'b0);
    chk("t3_hex_held", bus_if.hex_byte, 8'hA5);
    hold(G_5, 3'b001, 40);
    chk("t3_resync_fe", fe_cnt - fe0, 1);
    hold(G_MARK, 3'b100, 40);
    hold(G_3, 3'b010, 40);
    hold(G_C, 3'b001, 40);
    chk("t3_hex", bus_if.hex_byte, 8'h3C);
    chk("t3_relock", bus_if.locked, 1'b1);
    chk("t3_bv_count", bv_cnt - bv0, 1);

    // Decoding starts mid-frame on a low digit
    rst_n = 1'b0;
    hold(G_5, 3'b001, 2);
    rst_n = 1'b1;
    snap();
    hold(G_5, 3'b001, 38);
    chk("t4_hex_rst", bus_if.hex_byte, 8'h00);
    hold(G_MARK, 3'b100, 40);
    hold(G_1, 3'b010, 40);
    chk("t4_no_bv", bv_cnt - bv0, 0);
    chk("t4_no_fe", fe_cnt - fe0, 0);
    hold(G_2, 3'b001, 40);
    chk("t4_bv_count", bv_cnt - bv0, 1);
    chk("t4_hex", bus_if.hex_byte, 8'h12);

    // Lock on 7E then blank bus until timeout
    snap();
    hold(G_MARK, 3'b100, 40);
    hold(G_7, 3'b010, 40);
    put(G_E, 3'b001);
    e = -1;
    fall = -1;
    @(posedge clk);
    #1;
    for (int i = 1; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.byte_valid) begin
        e = i;
        break;
      end
    end
    chk("t5_latency", e, 18);
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk);
      #1;
      if (k == 22) put(8'h00, 3'b000);
      if (!bus_if.locked) begin
        fall = k;
        break;
      end
    end
    chk("t5_timeout_edge", fall, 1000);
    chk("t5_hex", bus_if.hex_byte, 8'h7E);
    chk("t5_fe_count", fe_cnt - fe0, 0);

    // Asynchronous reset while in S_LOW
    hold(G_MARK, 3'b100, 40);
    hold(G_A, 3'b010, 40);
    hold(G_5, 3'b001, 40);
    chk("t6_prelock", bus_if.locked, 1'b1);
    hold(G_MARK, 3'b100, 40);
    hold(G_0, 3'b010, 40);
    hold(G_5, 3'b001, 10);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_hex", bus_if.hex_byte, 8'h00);
    chk("t6_rst_locked", bus_if.locked, 1'b0);
    chk("t6_rst_bv", bus_if.byte_valid, 1'b0);
    chk("t6_rst_fe", bus_if.frame_error, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    snap();
    hold(8'h00, 3'b000, 40);
    hold(G_MARK, 3'b100, 40);
    hold(G_0, 3'b010, 40);
    hold(G_1, 3'b001, 40);
    chk("t6_hex", bus_if.hex_byte, 8'h01);
    chk("t6_locked", bus_if.locked, 1'b1);
    chk("t6_bv_count", bv_cnt - bv0, 1);
    chk("t6_fe_count", fe_cnt - fe0, 0);

    chk("pulse_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
